fsm_detector_arbiter: RTL
=========================

# fsm_detector_arbiter

Round-robin arbiter sharing one two-input sequence-detector FSM (inputs A, B; output Q) among N_REQ requesters. Each requester presents its own A/B stream and a request; the arbiter grants one requester at a time, muxes that requester's A/B onto the shared detector, and routes the detector's Q back to that requester only. It clears the detector between grants, so no detector state carries over from one requester to the next. Sits between the requester lanes and the single shared detector instance.

## Interface
- N_REQ, 4, number of requesters (≥2)
- MAX_HOLD, 8, maximum cycles a single grant lasts (≥1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to idle
- req  in  N_REQ  per-requester access request, level-sensitive
- a_in  in  N_REQ  per-requester A stream
- b_in  in  N_REQ  per-requester B stream
- det_q  in  1  Q output of shared detector
- gnt  out  N_REQ  one-hot grant, registered; all-zero when no grant
- det_a  out  1  A driven to detector = a_in[granted index], 0 when no grant
- det_b  out  1  B driven to detector = b_in[granted index], 0 when no grant
- det_clr  out  1  active-high synchronous clear to detector
- q_out  out  N_REQ  q_out[i] = det_q & gnt[i]
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: gnt=0, det_clr=1. If any req is high at an edge, go to GRANT; winner latched into gnt.
- GRANT: det_clr=0; hold counter starts at 0 on entry and increments each cycle.
  - Go to RELEASE when req[granted]=0 at an edge, or when the counter reaches MAX_HOLD-1 (grant lasted MAX_HOLD cycles).
  - On leaving, pointer ← granted index + 1 (mod N_REQ).
- RELEASE: exactly one cycle; gnt=0, det_clr=1. Then go to GRANT if any req is high (fresh arbitration using the updated pointer), else go to IDLE.
- Arbitration: pick the first high req scanning from pointer upward with wrap. Pointer is 0 after reset, so requester 0 has highest priority.
- Fairness: any continuously requesting lane is granted within (N_REQ-1)·(MAX_HOLD+1) cycles of the previous grant ending.
- det_a, det_b and q_out are combinational from gnt and the inputs. No extra register stage.
- req changes on non-granted lanes have no effect until the next arbitration point.
- A lane that raises req during RELEASE competes in that arbitration.
- Hold counter width: $clog2(MAX_HOLD+1); must not wrap.

## Timing
- Reset values (state after the edge with reset=1): state=IDLE, pointer=0, counter=0, gnt=0, det_a=0, det_b=0, det_clr=1, q_out=0, busy=0.
- Reset asserted mid-grant: the next edge forces IDLE regardless of req, and gnt drops immediately after that edge.
- Grant latency: req sampled high at edge k in IDLE → gnt high after edge k.
- Release latency: req[g] sampled low at edge k → gnt=0 and det_clr=1 after edge k.
- Gap: exactly one cycle between consecutive grants, always with det_clr=1.
- Release when no other req: RELEASE → IDLE. Still at most one cycle from release to gnt if a req then rises.
- Simultaneous release and re-request by the same lane: that lane is lowest priority in the following arbitration. It wins only if no other lane requests.
- MAX_HOLD=1: every grant lasts exactly 1 cycle.

## Structure
- Package fsm_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT, ARB_RELEASE}
  - default N_REQ and MAX_HOLD constants
- Sub-module fsm_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot pick, index, any.
- Top holds the state register, pointer, hold counter and output muxing.

## Test plan
1. reset=1 for 2 cycles with req=4'b1111 → gnt=0, det_clr=1, busy=0 throughout. After reset drops: gnt=4'b0001 after the next edge.
2. req=4'b0100 held, a_in[2]=1, b_in[2]=1, det_q=1 → gnt=4'b0100, det_a=1, det_b=1, q_out=4'b0100. Grant lasts 8 cycles, then 1 RELEASE cycle, then re-granted to lane 2.
3. req=4'b1111 held for 40 cycles → grant order 0,1,2,3,0. Each grant lasts 8 cycles, separated by 1-cycle det_clr=1 gaps.
4. Lane 1 granted, req[1] dropped after 3 cycles with req[3]=1 → RELEASE next cycle, then gnt=4'b1000.
5. Reset asserted during lane 2 grant (cycle 4 of hold) → IDLE after that edge. Next grant goes to the lowest-index requesting lane (pointer=0).
6. N_REQ=4, MAX_HOLD=1, req=4'b0011 → gnt alternates 4'b0001, 0, 4'b0010, 0, and so on.

Source files
------------

// File: rtl/fsm_arb_pkg.sv
// Shared types and default sizing for the round-robin
// arbiter that time-shares one sequence detector.
package fsm_arb_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_RELEASE
   } arb_state_t;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_MAX_HOLD = 8;
endpackage

// File: rtl/fsm_detector_arbiter_if.sv
// Requester-side lane bundle: per-lane request and A/B
// streams in, per-lane grant and routed Q out.
interface fsm_detector_arbiter_if
   import fsm_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] a_in;
   logic [N_REQ-1:0] b_in;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] q_out;

   modport master (
      output req, a_in, b_in,
      input  gnt, q_out
   );

   modport slave (
      input  req, a_in, b_in,
      output gnt, q_out
   );
endinterface

// File: rtl/fsm_rr_pick.sv
// Combinational round-robin picker: first high request
// at or above the pointer, wrapping past the top lane.
module fsm_rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   localparam int IW   = $clog2(N_REQ)
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_pick,
   output logic [IW-1:0]    o_idx,
   output logic             o_any
);
   int w_j;

   always_comb begin
      o_pick = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_j    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = (int'(i_ptr) + k) % N_REQ;
         if (!o_any && i_req[w_j]) begin
            o_any       = 1'b1;
            o_pick[w_j] = 1'b1;
            o_idx       = IW'(w_j);
         end
      end
   end
endmodule

// File: rtl/fsm_detector_arbiter.sv
// Round-robin arbiter sharing one A/B sequence detector
// among N_REQ lanes, clearing it between grants.
module fsm_detector_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD
)(
   input  logic                 clk,
   input  logic                 reset,
   fsm_detector_arbiter_if.slave lanes,
   input  logic                 det_q,
   output logic                 det_a,
   output logic                 det_b,
   output logic                 det_clr,
   output logic                 busy
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
   localparam logic [IW-1:0] IDX_TOP   = IW'(N_REQ - 1);

   arb_state_t       r_state, w_state_nx;
   logic [N_REQ-1:0] r_gnt, w_gnt_nx;
   logic [IW-1:0]    r_idx, w_idx_nx;
   logic [IW-1:0]    r_ptr, w_ptr_nx;
   logic [CW-1:0]    r_cnt, w_cnt_nx;

   logic [N_REQ-1:0] w_pick;
   logic [IW-1:0]    w_pick_idx;
   logic             w_any;
   logic             w_done;

   fsm_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req  (lanes.req),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_idx  (w_pick_idx),
      .o_any  (w_any)
   );

   assign w_done = !lanes.req[r_idx] || (r_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ARB_IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_gnt   <= w_gnt_nx;
         r_idx   <= w_idx_nx;
         r_ptr   <= w_ptr_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // IDLE and RELEASE both arbitrate; RELEASE sees the advanced pointer
   always_comb begin
      w_state_nx = r_state;
      w_gnt_nx   = r_gnt;
      w_idx_nx   = r_idx;
      w_ptr_nx   = r_ptr;
      w_cnt_nx   = r_cnt;
      unique case (r_state)
         ARB_IDLE, ARB_RELEASE: begin
            w_cnt_nx   = '0;
            w_gnt_nx   = w_pick;
            w_idx_nx   = w_pick_idx;
            w_state_nx = w_any ? ARB_GRANT : ARB_IDLE;
         end
         ARB_GRANT: begin
            if (w_done) begin
               w_state_nx = ARB_RELEASE;
               w_gnt_nx   = '0;
               w_ptr_nx   = (r_idx == IDX_TOP) ? '0 : r_idx + 1'b1;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nx = ARB_IDLE;
            w_gnt_nx   = '0;
         end
      endcase
   end

   assign lanes.gnt   = r_gnt;
   assign lanes.q_out = {N_REQ{det_q}} & r_gnt;
   assign det_a       = |(lanes.a_in & r_gnt);
   assign det_b       = |(lanes.b_in & r_gnt);
   assign det_clr     = (r_state != ARB_GRANT);
   assign busy        = (r_state != ARB_IDLE);
endmodule
